alu_multicycle: RTL and testbench

Parametrised datapath ALU that replaces the add-only ALU in the single-cycle datapath with a registered, start/done-handshaked unit. Single-cycle logic and arithmetic ops complete in one clock. Unsigned multiply and divide run iteratively over WIDTH clocks. The control unit stalls the PC while `busy` is high.

---
 rtl/alu_if.sv | 28 ++
 rtl/alu_multicycle.sv | 137 +++++++++++++
 tb/tb_alu_multicycle.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Start/done bus between the control unit and the multicycle ALU.
// Handshake: start is taken on a rising edge only while busy=0; done pulses for one
// cycle when results land, and results then hold until the next done or reset.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             ovf;
    logic             busy;
    logic             done;
    logic             state_dbg;

    modport master (
        output start, op, inA, inB,
        input  result, result_hi, zero, ovf, busy, done, state_dbg
    );

    modport slave (
        input  start, op, inA, inB,
        output result, result_hi, zero, ovf, busy, done, state_dbg
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU: logic/add/sub/slt finish in one clock; unsigned multiply (shift-add)
// and divide (restoring) iterate for WIDTH clocks on a shared accumulator pair.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    localparam int            CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_MULU = 3'b101;
    localparam logic [2:0] OP_DIVU = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] quick_res;
    logic             quick_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign bus.state_dbg = state;

    always_comb begin
        add_res   = bus.inA + bus.inB;
        sub_res   = bus.inA - bus.inB;
        quick_res = '0;
        quick_ovf = 1'b0;
        case (bus.op)
            OP_ADD: begin
                quick_res = add_res;
                quick_ovf = (bus.inA[WIDTH-1] == bus.inB[WIDTH-1]) &&
                            (add_res[WIDTH-1] != bus.inA[WIDTH-1]);
            end
            OP_SUB: begin
                quick_res = sub_res;
                quick_ovf = (bus.inA[WIDTH-1] != bus.inB[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != bus.inA[WIDTH-1]);
            end
            OP_AND:  quick_res = bus.inA & bus.inB;
            OP_OR:   quick_res = bus.inA | bus.inB;
            OP_XOR:  quick_res = bus.inA ^ bus.inB;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(bus.inA) < $signed(bus.inB))};
            default: ;
        endcase
    end

    // Multiply: acc_lo starts as the multiplier and is shifted out as product bits shift in.
    // Divide: acc_lo starts as the dividend and collects quotient bits; acc_hi is the remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            is_div        <= 1'b0;
            opnd          <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.zero      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MULU || bus.op == OP_DIVU) begin
                            state    <= ITER;
                            count    <= COUNT_INIT;
                            is_div   <= (bus.op == OP_DIVU);
                            opnd     <= (bus.op == OP_DIVU) ? bus.inB : bus.inA;
                            acc_lo   <= (bus.op == OP_DIVU) ? bus.inA : bus.inB;
                            acc_hi   <= '0;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.result    <= quick_res;
                            bus.result_hi <= '0;
                            bus.zero      <= (quick_res == '0);
                            bus.ovf       <= quick_ovf;
                            bus.done      <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.result    <= step_lo;
                        bus.result_hi <= step_hi;
                        bus.zero      <= (step_lo == '0);
                        bus.ovf       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_multicycle;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_MULU = 3'b101;
    localparam logic [2:0] OP_DIVU = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef struct packed {
        logic        unit;
        logic        iter;
        logic [31:0] due;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        o;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic chk_en;
    exp_t exp_q[$];
    int   last_due[2];
    logic [31:0] held_lo[2];
    logic [31:0] held_hi[2];
    logic        held_z[2];
    logic        held_o[2];

    alu_if #(.WIDTH(32)) b32 ();
    alu_if #(.WIDTH(8))  b8 ();

    alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_multicycle #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // reference model: plain arithmetic on the operand values
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned mask, ua, ub, p;
        longint sa, sb, s, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb   = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        smax = longint'(mask >> 1);
        smin = -smax - 1;
        e = '0;
        case (op)
            OP_ADD: begin
                s = sa + sb;
                e.lo = 32'((ua + ub) & mask);
                e.o  = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                s = sa - sb;
                e.lo = 32'((ua - ub) & mask);
                e.o  = (s > smax) || (s < smin);
            end
            OP_AND: e.lo = 32'(ua & ub);
            OP_OR:  e.lo = 32'(ua | ub);
            OP_XOR: e.lo = 32'(ua ^ ub);
            OP_SLT: e.lo = (sa < sb) ? 32'd1 : 32'd0;
            OP_MULU: begin
                p = ua * ub;
                e.lo = 32'(p & mask);
                e.hi = 32'((p >> w) & mask);
                e.iter = 1'b1;
            end
            default: begin
                if (ub == 0) begin
                    e.lo = 32'(mask);
                    e.hi = 32'(ua);
                end else begin
                    e.lo = 32'(ua / ub);
                    e.hi = 32'(ua % ub);
                end
                e.iter = 1'b1;
            end
        endcase
        e.z = (e.lo == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // scoreboard compare for one unit, run once per cycle
    task automatic check_unit(input int u, input logic [31:0] r, input logic [31:0] rh,
                              input logic z, input logic o, input logic b, input logic d);
        int    idx;
        int    w;
        logic  exp_b;
        string tag;
        exp_t  e;
        idx   = -1;
        exp_b = 1'b0;
        w     = (u == 0) ? 32 : 8;
        tag   = (u == 0) ? "u32" : "u8";
        foreach (exp_q[i]) begin
            if (int'(exp_q[i].unit) == u) begin
                if (idx < 0) idx = i;
                if (exp_q[i].iter && cyc >= int'(exp_q[i].due) - w && cyc < int'(exp_q[i].due))
                    exp_b = 1'b1;
            end
        end
        if (idx >= 0 && int'(exp_q[idx].due) == cyc) begin
            e = exp_q[idx];
            chk({tag, " done"}, {31'd0, d}, 32'd1);
            chk({tag, " result"}, r, e.lo);
            chk({tag, " result_hi"}, rh, e.hi);
            chk({tag, " zero"}, {31'd0, z}, {31'd0, e.z});
            chk({tag, " ovf"}, {31'd0, o}, {31'd0, e.o});
            held_lo[u] = e.lo;
            held_hi[u] = e.hi;
            held_z[u]  = e.z;
            held_o[u]  = e.o;
            exp_q.delete(idx);
        end else begin
            chk({tag, " done idle"}, {31'd0, d}, 32'd0);
            chk({tag, " result held"}, r, held_lo[u]);
            chk({tag, " result_hi held"}, rh, held_hi[u]);
            chk({tag, " zero held"}, {31'd0, z}, {31'd0, held_z[u]});
            chk({tag, " ovf held"}, {31'd0, o}, {31'd0, held_o[u]});
        end
        chk({tag, " busy"}, {31'd0, b}, {31'd0, exp_b});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_unit(0, b32.result, b32.result_hi, b32.zero, b32.ovf, b32.busy, b32.done);
            check_unit(1, {24'd0, b8.result}, {24'd0, b8.result_hi},
                       b8.zero, b8.ovf, b8.busy, b8.done);
        end
    end

    // driver tasks (always entered on a negedge)
    task automatic issue(input int u, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        int   w;
        w = (u == 0) ? 32 : 8;
        e = model(w, op, a, b);
        e.unit = u[0];
        e.due  = 32'(cyc + 1 + (e.iter ? w : 0));
        if (u == 0) begin
            b32.start = 1'b1; b32.op = op; b32.inA = a; b32.inB = b;
        end else begin
            b8.start = 1'b1; b8.op = op; b8.inA = a[7:0]; b8.inB = b[7:0];
        end
        exp_q.push_back(e);
        last_due[u] = int'(e.due);
        @(negedge clk);
        b32.start = 1'b0;
        b8.start  = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int n;
        n = 0;
        while (cyc < last_due[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_idle unit %0d: still waiting at cycle %0d, due %0d", u, cyc, last_due[u]);
        end
    endtask

    // scramble u32 inputs while it iterates, with stray start pulses that must be ignored
    task automatic jiggle(input int n);
        for (int i = 0; i < n; i++) begin
            b32.op    = 3'($urandom_range(0, 7));
            b32.inA   = $urandom;
            b32.inB   = $urandom;
            b32.start = (i % 5 == 2);
            @(negedge clk);
        end
        b32.start = 1'b0;
    endtask

    task automatic reset_outputs_check(input string name);
        chk({name, " busy"}, {31'd0, b32.busy}, 32'd0);
        chk({name, " done"}, {31'd0, b32.done}, 32'd0);
        chk({name, " result"}, b32.result, 32'd0);
        chk({name, " result_hi"}, b32.result_hi, 32'd0);
        chk({name, " zero"}, {31'd0, b32.zero}, 32'd0);
        chk({name, " ovf"}, {31'd0, b32.ovf}, 32'd0);
        chk({name, " u8 result"}, {24'd0, b8.result}, 32'd0);
        chk({name, " u8 busy"}, {31'd0, b8.busy}, 32'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int u = 0; u < 2; u++) begin
            held_lo[u] = '0; held_hi[u] = '0; held_z[u] = 1'b0; held_o[u] = 1'b0;
            last_due[u] = cyc;
        end
    endtask

    initial begin
        exp_t e;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        cyc = 0; checks = 0; errors = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        b32.start = 1'b0; b32.op = '0; b32.inA = '0; b32.inB = '0;
        b8.start  = 1'b0; b8.op  = '0; b8.inA  = '0; b8.inB  = '0;
        clear_model();

        // hand-computed pins on the reference model
        e = model(32, OP_ADD, 32'h7FFFFFFF, 32'h1);
        chk("model add lo", e.lo, 32'h80000000);
        chk("model add ovf", {31'd0, e.o}, 32'd1);
        e = model(32, OP_SUB, 32'd5, 32'd5);
        chk("model sub zero", {31'd0, e.z}, 32'd1);
        e = model(32, OP_SLT, 32'hFFFFFFFF, 32'd1);
        chk("model slt", e.lo, 32'd1);
        e = model(32, OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0);
        chk("model xor", e.lo, 32'hFF00FF00);
        e = model(32, OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("model mulu hi", e.hi, 32'hFFFFFFFE);
        chk("model mulu lo", e.lo, 32'h00000001);
        e = model(32, OP_DIVU, 32'd100, 32'd7);
        chk("model divu q", e.lo, 32'd14);
        chk("model divu r", e.hi, 32'd2);
        e = model(32, OP_DIVU, 32'd123, 32'd0);
        chk("model div0 q", e.lo, 32'hFFFFFFFF);
        chk("model div0 r", e.hi, 32'd123);
        e = model(8, OP_MULU, 32'hFF, 32'hFF);
        chk("model mulu8 hi", e.hi, 32'h000000FE);

        // reset hold and release
        repeat (3) @(negedge clk);
        reset_outputs_check("in reset");
        rst_n = 1'b1;
        clear_model();
        chk_en = 1'b1;
        @(negedge clk);
        reset_outputs_check("after reset");

        // single-cycle ops, back to back
        issue(0, OP_ADD, 32'h7FFFFFFF, 32'h1);
        issue(0, OP_SUB, 32'd5, 32'd5);
        issue(0, OP_SLT, 32'hFFFFFFFF, 32'd1);
        issue(0, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0);
        issue(0, OP_OR,  32'hF0F0F0F0, 32'h0FF00FF0);
        issue(0, OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0);
        issue(0, OP_SUB, 32'h80000000, 32'h1);
        issue(0, OP_ADD, 32'hFFFFFFFF, 32'h1);
        @(negedge clk);

        // MULU with scrambled inputs, then DIVU started in the done cycle
        issue(0, OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        jiggle(20);
        wait_idle(0);
        issue(0, OP_DIVU, 32'd100, 32'd7);
        jiggle(15);
        wait_idle(0);
        issue(0, OP_DIVU, 32'd123, 32'd0);
        jiggle(25);
        wait_idle(0);
        @(negedge clk);

        // reset in the middle of an iterative op
        issue(0, OP_MULU, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        reset_outputs_check("mid-iter reset");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (40) @(negedge clk);

        // random sweep, WIDTH=32
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            wait_idle(0);
            issue(0, op, a, b);
        end
        wait_idle(0);

        // random sweep, WIDTH=8
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(0, 255);
            wait_idle(1);
            issue(1, op, a, b);
        end
        wait_idle(1);
        issue(1, OP_MULU, 32'hFF, 32'hFF);
        wait_idle(1);
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending results: %0d left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
